// File: rtl/tone_detect_if.sv
// CPU-side register interface of tone_detect: result outputs plus the
// one-cycle read pulse that acknowledges the current result.
interface tone_detect_if #(
    parameter int unsigned WIDTH = 32
);
    logic             rd_req;
    logic [WIDTH-1:0] half_out;
    logic [WIDTH-1:0] div_out;
    logic             valid;
    logic             overrun;
    logic             silent;

    // CPU side
    modport master (
        output rd_req,
        input  half_out,
        input  div_out,
        input  valid,
        input  overrun,
        input  silent
    );

    // Peripheral side
    modport slave (
        input  rd_req,
        output half_out,
        output div_out,
        output valid,
        output overrun,
        output silent
    );
endinterface

// File: rtl/tone_detect.sv
// Square-wave half-period meter: reports clocks between input edges and the
// matching tonegen divider, flags silence on timeout. Option: TONE_DETECT_AVG_EN.
module tone_detect #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tone_in,
    tone_detect_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       half_q, half_d;
    logic [WIDTH-1:0]       div_q, div_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   silent_q, silent_d;

    logic                   edge_det;
    logic                   cnt_at_timeout;
    logic                   measure;
    logic                   timeout_hit;
    logic                   pub_silence;
    logic                   meas_pub;
    logic [WIDTH-1:0]       meas_h;
    logic                   publish;
    logic [WIDTH-1:0]       pub_h;

    // Edge detector and half-period counter
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sync_d         = {sync_q[SYNC_STAGES-2:0], tone_in};
        hist_d         = sync_q[SYNC_STAGES-1];
        edge_det       = sync_q[SYNC_STAGES-1] ^ hist_q;
        cnt_at_timeout = (cnt_q == TIMEOUT);
        if (edge_det) begin
            cnt_d = ONE;
        end else if (cnt_at_timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // FSM next state; an edge always takes priority over a timeout.
    always_comb begin
        state_d     = state_q;
        measure     = 1'b0;
        timeout_hit = 1'b0;
        pub_silence = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (edge_det) begin
                    state_d = LOCKED;
                    measure = 1'b1;
                end else if (cnt_at_timeout) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    measure = 1'b1;
                end else if (cnt_at_timeout) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                    pub_silence = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TONE_DETECT_AVG_EN
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [1:0]       avg_cnt_q, avg_cnt_d;
    logic [WIDTH+1:0] acc_sum;

    // Four consecutive measurements are summed; only the 4th publishes.
    always_comb begin
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        meas_pub  = 1'b0;
        meas_h    = '0;
        acc_sum   = acc_q + {2'b00, cnt_q};
        if (timeout_hit) begin
            acc_d     = '0;
            avg_cnt_d = 2'd0;
        end else if (measure) begin
            if (avg_cnt_q == 2'd3) begin
                meas_pub  = 1'b1;
                meas_h    = acc_sum[WIDTH+1:2];
                acc_d     = '0;
                avg_cnt_d = 2'd0;
            end else begin
                acc_d     = acc_sum;
                avg_cnt_d = avg_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            avg_cnt_q <= 2'd0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`else
    assign meas_pub = measure;
    assign meas_h   = cnt_q;
`endif

    // Result registers and read handshake; a publish overrides rd_req.
    always_comb begin
        half_d    = half_q;
        div_d     = div_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        silent_d  = silent_q;
        publish   = meas_pub | pub_silence;
        pub_h     = pub_silence ? '0 : meas_h;
        if (publish) begin
            half_d    = pub_h;
            div_d     = (pub_h >= TWO) ? (pub_h - TWO) : '0;
            silent_d  = pub_silence;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~bus.rd_req;
        end else if (bus.rd_req && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            cnt_q     <= '0;
            half_q    <= '0;
            div_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            silent_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            div_q     <= div_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            silent_q  <= silent_d;
        end
    end

    assign bus.half_out = half_q;
    assign bus.div_out  = div_q;
    assign bus.valid    = valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.silent   = silent_q;

endmodule
